// File: rtl/checker_arbiter.sv
// Purpose: shares one cpu_checker between NUM_REQ character sources, one whole
//          message ('^'..'#') at a time, and returns the checker result tagged with the source id.
// Latency: accepted char -> o_chk_char 1 cycle; '#' accept -> o_res_valid RESULT_LAT+2 cycles.
// Backpressure: o_req_ready is combinational; only the granted source is ever accepted, and a
//               bubble or overlong message aborts it.
// Ports:
//   i_clk, i_rst_n                   clock / async active-low reset
//   i_req_valid/i_req_char/o_req_ready  per-source character stream (source i = char bits [8i+7:8i])
//   i_freq                           frequency config, latched at grant
//   o_chk_char, o_chk_freq           registered drive into the shared checker
//   i_chk_format_type, i_chk_error_code  checker result inputs
//   o_res_valid/_src/_format/_error/_abort  one-cycle tagged result
//   o_busy                           arbiter is not idle
module checker_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int SRC_W      = 3,
  parameter int MAX_LEN    = 64,
  parameter int RESULT_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_char,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [15:0]          i_freq,
  output logic [7:0]           o_chk_char,
  output logic [15:0]          o_chk_freq,
  input  logic [1:0]           i_chk_format_type,
  input  logic [3:0]           i_chk_error_code,
  output logic                 o_res_valid,
  output logic [SRC_W-1:0]     o_res_src,
  output logic [1:0]           o_res_format,
  output logic [3:0]           o_res_error,
  output logic                 o_res_abort,
  output logic                 o_busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = (RESULT_LAT < 1) ? 1 : $clog2(RESULT_LAT + 1);
  localparam logic [7:0] CARET = 8'h5E;
  localparam logic [7:0] HASH  = 8'h23;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_RES, S_ABORT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SRC_W-1:0]  r_rr;
  logic [SRC_W-1:0]  r_gnt;
  logic [LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_chk_char;
  logic [15:0]       r_chk_freq;
  logic              r_res_valid;
  logic [SRC_W-1:0]  r_res_src;
  logic [1:0]        r_res_format;
  logic [3:0]        r_res_error;
  logic              r_res_abort;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_any;
  logic [SRC_W-1:0]   w_win;
  logic               w_g_vld;
  logic [7:0]         w_g_char;
  logic               w_room;
  logic               w_accept;

  // A source may only open a message with '^'.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = i_req_valid[i] && (i_req_char[8*i +: 8] == CARET);
    end
  end

  // Round-robin search starting at r_rr; the outer loop sets priority order.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && w_elig[i] && (i == ((int'(r_rr) + k) % NUM_REQ))) begin
          w_any = 1'b1;
          w_win = SRC_W'(i);
        end
      end
    end
  end

  // Mux out the granted source's stream.
  always_comb begin
    w_g_vld  = 1'b0;
    w_g_char = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt == SRC_W'(i)) begin
        w_g_vld  = i_req_valid[i];
        w_g_char = i_req_char[8*i +: 8];
      end
    end
  end

  // Once MAX_LEN chars are in without '#', nothing more is accepted.
  assign w_room   = (r_len < LEN_W'(MAX_LEN));
  assign w_accept = (r_state == S_STREAM) && w_g_vld && w_room;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_any) w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (!w_room || !w_g_vld) w_state_nxt = S_ABORT;
        else if (w_g_char == HASH) w_state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: if (r_cnt == '0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Ready is held low while reset is asserted so an eligible '^'
  // is not acknowledged during reset.
  always_comb begin
    o_req_ready = '0;
    if (i_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_state == S_IDLE)
          o_req_ready[i] = w_any && (w_win == SRC_W'(i));
        else if (r_state == S_STREAM)
          o_req_ready[i] = (r_gnt == SRC_W'(i)) && w_g_vld && w_room;
      end
    end
    o_busy = (r_state != S_IDLE);
  end

  // Datapath: checker drive, length/latency counters and result capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr         <= '0;
      r_gnt        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_chk_char   <= 8'h00;
      r_chk_freq   <= 16'h0000;
      r_res_valid  <= 1'b0;
      r_res_src    <= '0;
      r_res_format <= 2'b00;
      r_res_error  <= 4'h0;
      r_res_abort  <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_chk_char <= CARET;
            r_chk_freq <= i_freq;
            r_len      <= LEN_W'(1);
            r_gnt      <= w_win;
            r_rr       <= (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + SRC_W'(1);
          end else begin
            r_chk_char <= 8'h00;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            r_chk_char <= w_g_char;
            r_len      <= r_len + LEN_W'(1);
            if (w_g_char == HASH) r_cnt <= CNT_W'(RESULT_LAT);
          end else begin
            // Bubble or length overrun: never forward a gap inside a message.
            r_chk_char <= 8'h00;
          end
        end
        S_WAIT_RES: begin
          r_chk_char <= 8'h00;
          if (r_cnt == '0) begin
            r_res_valid  <= 1'b1;
            r_res_src    <= r_gnt;
            r_res_format <= i_chk_format_type;
            r_res_error  <= i_chk_error_code;
            r_res_abort  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_chk_char   <= 8'h00;
          r_res_valid  <= 1'b1;
          r_res_src    <= r_gnt;
          r_res_format <= 2'b00;
          r_res_error  <= 4'h0;
          r_res_abort  <= 1'b1;
        end
      endcase
    end
  end

  assign o_chk_char   = r_chk_char;
  assign o_chk_freq   = r_chk_freq;
  assign o_res_valid  = r_res_valid;
  assign o_res_src    = r_res_src;
  assign o_res_format = r_res_format;
  assign o_res_error  = r_res_error;
  assign o_res_abort  = r_res_abort;

endmodule

// File: tb/tb_checker_arbiter.sv
// Purpose: self-checking bench for checker_arbiter with a behavioural checker stub
//          and a result scoreboard; a second instance exercises a short MAX_LEN.
// Latency: n/a. Backpressure: sources hold their chars until accepted.
module tb_checker_arbiter;

  typedef struct {
    int src;
    int fmt;
    int err;
    int abort;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          hash_cyc = 0;

  // main instance (MAX_LEN=64)
  logic [1:0]  req_valid = '0;
  logic [15:0] req_char = '0;
  logic [1:0]  req_ready;
  logic [15:0] freq = '0;
  logic [7:0]  chk_char;
  logic [15:0] chk_freq;
  logic [1:0]  mock_fmt_q = '0;
  logic [3:0]  mock_err_q = '0;
  logic [1:0]  mock_fmt = '0;
  logic [3:0]  mock_err = '0;
  logic        res_valid;
  logic [2:0]  res_src;
  logic [1:0]  res_format;
  logic [3:0]  res_error;
  logic        res_abort;
  logic        busy;

  // short-message instance (MAX_LEN=8)
  logic [1:0]  m_req_valid = '0;
  logic [15:0] m_req_char = '0;
  logic [1:0]  m_req_ready;
  logic [15:0] m_freq = '0;
  logic [7:0]  m_chk_char;
  logic [15:0] m_chk_freq;
  logic [1:0]  m_fmt_in = '0;
  logic [3:0]  m_err_in = '0;
  logic        m_res_valid;
  logic [2:0]  m_res_src;
  logic [1:0]  m_res_format;
  logic [3:0]  m_res_error;
  logic        m_res_abort;
  logic        m_busy;

  exp_t q0[$];
  exp_t q8[$];
  exp_t e0;
  exp_t e8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  checker_arbiter #(.NUM_REQ(2), .SRC_W(3), .MAX_LEN(64), .RESULT_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_char(req_char), .o_req_ready(req_ready),
    .i_freq(freq), .o_chk_char(chk_char), .o_chk_freq(chk_freq),
    .i_chk_format_type(mock_fmt_q), .i_chk_error_code(mock_err_q),
    .o_res_valid(res_valid), .o_res_src(res_src), .o_res_format(res_format),
    .o_res_error(res_error), .o_res_abort(res_abort), .o_busy(busy)
  );

  checker_arbiter #(.NUM_REQ(2), .SRC_W(3), .MAX_LEN(8), .RESULT_LAT(1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(m_req_valid), .i_req_char(m_req_char), .o_req_ready(m_req_ready),
    .i_freq(m_freq), .o_chk_char(m_chk_char), .o_chk_freq(m_chk_freq),
    .i_chk_format_type(m_fmt_in), .i_chk_error_code(m_err_in),
    .o_res_valid(m_res_valid), .o_res_src(m_res_src), .o_res_format(m_res_format),
    .o_res_error(m_res_error), .o_res_abort(m_res_abort), .o_busy(m_busy)
  );

  // Checker stub: result valid only in the cycle after '#' sits on chk_char,
  // so a DUT sampling one cycle early or late picks up zeros.
  always @(posedge clk) begin
    if (chk_char == 8'h23) begin
      mock_fmt_q <= mock_fmt;
      mock_err_q <= mock_err;
    end else begin
      mock_fmt_q <= 2'b00;
      mock_err_q <= 4'h0;
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumers
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (q0.size() == 0) begin
        check_eq("res_unexpected", 1, 0);
      end else begin
        e0 = q0.pop_front();
        check_eq("res_src", res_src, e0.src);
        check_eq("res_format", res_format, e0.fmt);
        check_eq("res_error", res_error, e0.err);
        check_eq("res_abort", res_abort, e0.abort);
        if (e0.abort == 0) check_eq("res_latency", cyc - hash_cyc, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (m_res_valid === 1'b1) begin
      if (q8.size() == 0) begin
        check_eq("m_res_unexpected", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check_eq("m_res_src", m_res_src, e8.src);
        check_eq("m_res_format", m_res_format, e8.fmt);
        check_eq("m_res_error", m_res_error, e8.err);
        check_eq("m_res_abort", m_res_abort, e8.abort);
      end
    end
  end

  task automatic wait_res();
    bit seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check_eq("res_timeout", 0, 1);
  endtask

  // Streams msg from src starting now (just after a negedge); returns in the res_valid cycle.
  task automatic send(input int src, input string msg, input int fmt, input int err,
                      input bit abort, input int fq);
    exp_t e;
    byte  c;
    e.src = src;
    e.fmt = abort ? 0 : fmt;
    e.err = abort ? 0 : err;
    e.abort = abort ? 1 : 0;
    q0.push_back(e);
    mock_fmt = 2'(fmt);
    mock_err = 4'(err);
    freq = 16'(fq);
    for (int i = 0; i < msg.len(); i++) begin
      c = msg[i];
      req_valid[src] = 1'b1;
      req_char[8*src +: 8] = c;
      if (c == 8'h23) hash_cyc = cyc;
      #1;
      check_eq("req_ready_gnt", (int'(req_ready) >> src) & 1, 1);
      check_eq("req_ready_other", int'(req_ready) & ~(1 << src), 0);
      @(negedge clk);
      check_eq("chk_char_echo", chk_char, c);
      if (i == 0) begin
        check_eq("chk_freq_grant", chk_freq, fq);
        freq = 16'(fq + 5);
      end
    end
    req_valid[src] = 1'b0;
    if (abort) begin
      @(negedge clk);
      check_eq("abort_chk_char", chk_char, 0);
    end
    check_eq("chk_freq_hold", chk_freq, fq);
    wait_res();
  endtask

  task automatic check_reset_vals();
    check_eq("rst_chk_char", chk_char, 0);
    check_eq("rst_chk_freq", chk_freq, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_src", res_src, 0);
    check_eq("rst_res_abort", res_abort, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    m_req_valid = '0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string m9;
    byte   c;
    exp_t  e;
    do_reset();

    // Non-'^' char in IDLE is ignored.
    req_valid[0] = 1'b1;
    req_char[7:0] = 8'h61;
    #1;
    check_eq("idle_a_ready", req_ready, 0);
    check_eq("idle_a_busy", busy, 0);
    @(negedge clk);
    check_eq("idle_a_chk_char", chk_char, 0);
    check_eq("idle_a_busy2", busy, 0);
    req_valid[0] = 1'b0;

    // Full message from source 0.
    send(0, "^1023@000020fc: *32 <= 89abcdef#", 2, 0, 1'b0, 2);

    // Round robin from rr=0: both request together.
    do_reset();
    req_valid[1] = 1'b1;
    req_char[15:8] = 8'h5E;
    send(0, "^12#", 1, 5, 1'b0, 3);
    send(1, "^34#", 3, 9, 1'b0, 4);

    // Bubble after "^10" aborts.
    send(0, "^10", 1, 1, 1'b1, 5);

    // Reset in the middle of a message.
    req_valid[0] = 1'b1;
    req_char[7:0] = 8'h5E;
    @(negedge clk);
    req_char[7:0] = 8'h31;
    @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid[1] = 1'b1;
    req_char[15:8] = 8'h5E;
    send(1, "^5#", 2, 3, 1'b0, 6);

    // MAX_LEN=8: nine chars, no '#'.
    m9 = "^abcdefgh";
    e.src = 1; e.fmt = 0; e.err = 0; e.abort = 1;
    q8.push_back(e);
    m_freq = 16'd9;
    for (int i = 0; i < 9; i++) begin
      c = m9[i];
      m_req_valid[1] = 1'b1;
      m_req_char[15:8] = c;
      #1;
      check_eq("m_ready", m_req_ready[1], (i < 8) ? 1 : 0);
      @(negedge clk);
      check_eq("m_chk_char", m_chk_char, (i < 8) ? int'(c) : 0);
    end
    m_req_valid[1] = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (m_res_valid === 1'b1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) check_eq("m_res_timeout", 0, 1);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", q0.size(), 0);
    check_eq("m_sb_empty", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
